// File: rtl/ram_bus_master_pkg.sv
// Shared bus definitions for both ends of the RAM bus: state encodings,
// I/O opcode constants with their read/write class decode, and the
// phase numbers inside an instruction cycle where the bus carries traffic.
package ram_bus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SRC  = 2'd1,
        ST_IO   = 2'd2
    } busState_t;

    localparam logic [3:0] OP_WRM = 4'h0;
    localparam logic [3:0] OP_WMP = 4'h1;
    localparam logic [3:0] OP_WR0 = 4'h4;
    localparam logic [3:0] OP_WR1 = 4'h5;
    localparam logic [3:0] OP_WR2 = 4'h6;
    localparam logic [3:0] OP_WR3 = 4'h7;
    localparam logic [3:0] OP_SBM = 4'h8;
    localparam logic [3:0] OP_RDM = 4'h9;
    localparam logic [3:0] OP_ADM = 4'hB;
    localparam logic [3:0] OP_RD0 = 4'hC;
    localparam logic [3:0] OP_RD1 = 4'hD;
    localparam logic [3:0] OP_RD2 = 4'hE;
    localparam logic [3:0] OP_RD3 = 4'hF;

    localparam logic [2:0] PHASE_OPCODE = 3'd4;
    localparam logic [2:0] PHASE_XFER   = 3'd6;
    localparam logic [2:0] PHASE_SYNC   = 3'd7;

    // Ops whose data nibble travels from the master to the RAM.
    function automatic logic isWriteOp(input logic [3:0] op);
        case (op)
            OP_WRM, OP_WMP, OP_WR0, OP_WR1, OP_WR2, OP_WR3: isWriteOp = 1'b1;
            default:                                        isWriteOp = 1'b0;
        endcase
    endfunction

    // Ops whose data nibble travels from the RAM back to the master.
    function automatic logic isReadOp(input logic [3:0] op);
        case (op)
            OP_SBM, OP_RDM, OP_ADM, OP_RD0, OP_RD1, OP_RD2, OP_RD3: isReadOp = 1'b1;
            default:                                                isReadOp = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_bus_master_if.sv
// Host request/response handshake plus the shared 4-bit RAM bus.
// The master modport is the bus-driving agent; slave is everything facing it.
interface ram_bus_master_if;

    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic       req_chip;
    logic [1:0] req_reg;
    logic [3:0] req_char;
    logic [3:0] req_wdata;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       sync;
    logic       cmd_n;
    logic [3:0] data_o;
    logic       data_en;
    logic [3:0] data_i;

    modport master (
        input  req_valid, req_op, req_chip, req_reg, req_char, req_wdata, data_i,
        output req_ready, rsp_valid, rsp_data, sync, cmd_n, data_o, data_en
    );

    modport slave (
        output req_valid, req_op, req_chip, req_reg, req_char, req_wdata, data_i,
        input  req_ready, rsp_valid, rsp_data, sync, cmd_n, data_o, data_en
    );

endinterface

// File: rtl/bus_phase.sv
// Free-running eight-phase instruction-cycle counter with the sync marker.
// Any agent on the bus can instantiate this to stay in lockstep.
module bus_phase
    import ram_bus_master_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [2:0] o_phase,
    output logic       o_sync
);

    logic [2:0] r_phase;

    // Advance one phase per clock, wrapping 7 back to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase <= 3'd0;
        end else begin
            r_phase <= r_phase + 3'd1;
        end
    end

    assign o_phase = r_phase;
    assign o_sync  = !reset && (r_phase == PHASE_SYNC);

endmodule

// File: rtl/ram_bus_master.sv
// Bus master that turns one host request into a SRC cycle (address,
// character) followed by an IO cycle (opcode, data), then reports the result.
module ram_bus_master
    import ram_bus_master_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    ram_bus_master_if.master  bus
);

    logic [2:0] w_phase;
    logic       w_sync;
    logic       w_lastPhase;
    logic       w_ready;
    logic       w_accept;
    busState_t  r_state;
    busState_t  w_nextState;
    logic [3:0] r_op;
    logic       r_chip;
    logic [1:0] r_reg;
    logic [3:0] r_char;
    logic [3:0] r_wdata;
    logic [3:0] r_rspData;
    logic       w_cmdN;
    logic       w_dataEn;
    logic [3:0] w_dataO;
    logic       w_rspValid;

    bus_phase u_busPhase (
        .clock   (clock),
        .reset   (reset),
        .o_phase (w_phase),
        .o_sync  (w_sync)
    );

    assign w_lastPhase = (w_phase == PHASE_SYNC);
    assign w_ready     = !reset && w_lastPhase && ((r_state == ST_IDLE) || (r_state == ST_IO));
    assign w_accept    = w_ready && bus.req_valid;

    // State only moves at the end of an instruction cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (w_lastPhase) begin
            r_state <= w_nextState;
        end
    end

    // A new request can start straight after an IO cycle without idling.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_nextState = ST_SRC;
            ST_SRC:  w_nextState = ST_IO;
            ST_IO:   w_nextState = w_accept ? ST_SRC : ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Capture the whole request on the accept edge so later input changes are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op    <= 4'h0;
            r_chip  <= 1'b0;
            r_reg   <= 2'd0;
            r_char  <= 4'h0;
            r_wdata <= 4'h0;
        end else if (w_accept) begin
            r_op    <= bus.req_op;
            r_chip  <= bus.req_chip;
            r_reg   <= bus.req_reg;
            r_char  <= bus.req_char;
            r_wdata <= bus.req_wdata;
        end
    end

    // Sample the RAM's answer at the end of IO phase 6; non-read ops report zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rspData <= 4'h0;
        end else if ((r_state == ST_IO) && (w_phase == PHASE_XFER)) begin
            r_rspData <= isReadOp(r_op) ? bus.data_i : 4'h0;
        end
    end

    // Drive the bus according to where we are in the SRC/IO instruction cycles.
    always_comb begin
        w_cmdN     = 1'b1;
        w_dataEn   = 1'b0;
        w_dataO    = 4'h0;
        w_rspValid = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_SRC: begin
                    if (w_phase == PHASE_XFER) begin
                        w_cmdN   = 1'b0;
                        w_dataEn = 1'b1;
                        w_dataO  = {1'b0, r_chip, r_reg};
                    end else if (w_phase == PHASE_SYNC) begin
                        w_dataEn = 1'b1;
                        w_dataO  = r_char;
                    end
                end
                ST_IO: begin
                    if (w_phase == PHASE_OPCODE) begin
                        w_cmdN   = 1'b0;
                        w_dataEn = 1'b1;
                        w_dataO  = r_op;
                    end else if ((w_phase == PHASE_XFER) && isWriteOp(r_op)) begin
                        w_dataEn = 1'b1;
                        w_dataO  = r_wdata;
                    end else if (w_phase == PHASE_SYNC) begin
                        w_rspValid = 1'b1;
                    end
                end
                default: begin
                    w_cmdN = 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.sync      = w_sync;
    assign bus.cmd_n     = w_cmdN;
    assign bus.data_en   = w_dataEn;
    assign bus.data_o    = w_dataO;
    assign bus.rsp_valid = w_rspValid;
    assign bus.rsp_data  = reset ? 4'h0 : r_rspData;

endmodule

// File: doc/ram_bus_master.md
RAM_BUS_MASTER -- requirements
Module: ram_bus_master

Interface
REQ-001 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port req_valid  input  1  host request present.
REQ-004 SHALL have port req_ready  output  1  request accepted on this edge when high with req_valid.
REQ-005 SHALL have port req_op  input  4  I/O opcode nibble: 0 WRM, 1 WMP, 4-7 WR0-3, 8 SBM, 9 RDM, B ADM, C-F RD0-3; 2, 3, A are no-ops.
REQ-006 SHALL have ports req_chip (input, 1: chip-select bit), req_reg (input, 2: register index), req_char (input, 4: character index) and req_wdata (input, 4: write data).
REQ-007 SHALL have port rsp_valid  output  1  one-clock pulse on transaction completion.
REQ-008 SHALL have port rsp_data  output  4  read data; 0 for non-read opcodes.
REQ-009 SHALL have ports sync (output, 1), cmd_n (output, 1, active-low command strobe), data_o (output, 4), data_en (output, 1: drive enable) and data_i (input, 4: bus sampled value).

Function
REQ-010 SHALL run a free-running 3-bit phase counter: 0 after reset, +1 per clock, wraps 7->0; one instruction cycle spans phases 0-7.
REQ-011 SHALL assert sync exactly in phase 7.
REQ-012 SHALL use FSM states IDLE, SRC and IO, advancing only at the end of phase 7: IDLE->SRC on accept; SRC->IO always; IO->SRC on accept, otherwise IO->IDLE.
REQ-013 SHALL drive req_ready = (phase==7) && (state is IDLE or IO); a request is accepted when req_valid && req_ready, and all req_* fields are latched on that edge.
REQ-014 In SRC phase 6, SHALL drive cmd_n=0, data_en=1 and data_o={1'b0, chip, reg}.
REQ-015 In SRC phase 7, SHALL drive cmd_n=1, data_en=1 and data_o=char.
REQ-016 In IO phase 4, SHALL drive cmd_n=0, data_en=1 and data_o=op.
REQ-017 In IO phase 6, SHALL keep cmd_n=1; for write-class ops (0, 1, 4-7) SHALL drive data_en=1 and data_o=wdata.
REQ-018 In IO phase 6, for read-class ops (8, 9, B, C-F) SHALL keep data_en=0 and capture data_i into rsp_data on the phase-6 edge.
REQ-019 In IO phase 7, SHALL pulse rsp_valid for exactly one clock; rsp_data SHALL hold its value until the next completion and SHALL be 0 for non-read ops.
REQ-020 In all other phase/state combinations, SHALL drive cmd_n=1, data_en=0 and data_o=0.
REQ-021 A back-to-back accept in IO phase 7 SHALL coincide with that transaction's rsp_valid pulse; the next SRC cycle SHALL start at the following phase 0 with no gap.
REQ-022 Total latency from accept edge to rsp_valid SHALL be 16 clocks.
REQ-023 Request fields SHALL be ignored when no accept occurs; request inputs changing mid-transaction SHALL have no effect.

Reset
REQ-024 SHALL force phase=0, state=IDLE, cmd_n=1, sync=0, data_en=0, data_o=0, req_ready=0, rsp_valid=0 and rsp_data=0 while reset is high.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no rsp_valid pulse; the first accept opportunity after reset release SHALL be at phase 7.

Structure
REQ-026 Opcode constants and their read/write class decode, the FSM state encodings and phase numbers 4/6/7 SHALL live in a shared bus-definitions package/header used by both bus ends.
REQ-027 The phase counter plus sync generation SHALL be a sub-module named bus_phase, reusable by other bus agents.

Verification
REQ-028 Bus-level check: with the RAM responder on a shared reset and p0=1, request op=0, chip=1, reg=2, char=5, wdata=A -> SRC phase 6 data_o=6 with cmd_n=0; phase 7 data_o=5; IO phase 4 data_o=0 with cmd_n=0; IO phase 6 data_o=A with data_en=1.
REQ-029 Write then read: the REQ-028 write, then op=9 at the same address -> rsp_valid 16 clocks after accept with rsp_data=A.
REQ-030 Status path: op=5 with wdata=3 (chip 1, reg 0), then op=D -> rsp_data=3; op=D on chip 0 (unselected) -> rsp_data=0 with data_en never high in IO phase 6.
REQ-031 Back-to-back: req_valid held high for three requests -> accepts every 16 clocks, each rsp_valid coincident with the next accept, and cmd_n never low in IO phase 6.
REQ-032 Reset mid-IO: assert reset in IO phase 5 -> no rsp_valid, all outputs at reset values, and the next request after release completes correctly.
